// File: rtl/bit_sweep_unit_if.sv
// Request/response bundle for bit_sweep_unit: request fields, handshake and result.
interface bit_sweep_unit_if #(
  parameter int N  = 8,
  parameter int LW = $clog2(N) + 1
);
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_op;
  logic [N-1:0]  i_a;
  logic [N-1:0]  i_b;
  logic [LW-1:0] i_len;
  logic          o_valid;
  logic [N-1:0]  o_out;
  logic          o_flag;
  logic          o_ERR;

  modport master (
    output i_valid, i_op, i_a, i_b, i_len,
    input  o_ready, o_valid, o_out, o_flag, o_ERR
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_len,
    output o_ready, o_valid, o_out, o_flag, o_ERR
  );
endinterface

// File: rtl/bit_sweep_unit.sv
// bit_sweep_unit: walks a run of consecutive bits of a word one bit per cycle,
// toggling, setting, clearing or testing each. Bad requests finish in one cycle
// with an error flag.
module bit_sweep_unit #(
  parameter int N  = 8,
  parameter int LW = $clog2(N) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  bit_sweep_unit_if.slave  bus
);
  // Sum width wide enough that magnitude + length can never wrap.
  localparam int SW = (((N - 1) > LW) ? (N - 1) : LW) + 1;

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TEST   = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_op;
  logic [N-1:0]  r_word;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_rem;
  logic          r_acc;

  logic [SW-1:0] w_mag_x, w_len_x, w_sum;
  logic          w_err;
  logic [N-1:0]  w_mask, w_word_nxt;
  logic          w_bit, w_last;

  assign w_mag_x = {{(SW-N+1){1'b0}}, bus.i_b[N-2:0]};
  assign w_len_x = {{(SW-LW){1'b0}}, bus.i_len};
  assign w_sum   = w_mag_x + w_len_x;
  assign w_err   = bus.i_b[N-1] | (w_mag_x >= SW'(N)) | (bus.i_len == '0) | (w_sum > SW'(N));

  assign w_mask = {{(N-1){1'b0}}, 1'b1} << r_idx;
  assign w_bit  = |(r_word & w_mask);
  assign w_last = (r_rem == LW'(1));

  // Apply the selected operation to the bit under the cursor.
  always_comb begin
    w_word_nxt = r_word;
    case (r_op)
      OP_TOGGLE: w_word_nxt = r_word ^ w_mask;
      OP_SET:    w_word_nxt = r_word | w_mask;
      OP_CLEAR:  w_word_nxt = r_word & ~w_mask;
      default:   w_word_nxt = r_word;
    endcase
  end

  // Next-state logic: errors skip RUN, the last bit moves to DONE, DONE is one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.i_valid) w_state_nxt = w_err ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath: capture on accept, step one bit per RUN cycle, load results entering DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= '0;
      r_word     <= '0;
      r_idx      <= '0;
      r_rem      <= '0;
      r_acc      <= 1'b0;
      bus.o_out  <= '0;
      bus.o_flag <= 1'b0;
      bus.o_ERR  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_op   <= bus.i_op;
            r_word <= bus.i_a;
            r_idx  <= w_mag_x[LW-1:0];
            r_rem  <= bus.i_len;
            r_acc  <= 1'b0;
            if (w_err) begin
              bus.o_out  <= '0;
              bus.o_flag <= 1'b0;
              bus.o_ERR  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_word <= w_word_nxt;
          r_acc  <= r_acc | w_bit;
          r_idx  <= r_idx + LW'(1);
          r_rem  <= r_rem - LW'(1);
          if (w_last) begin
            bus.o_out  <= w_word_nxt;
            bus.o_flag <= (r_op == OP_TEST) & (r_acc | w_bit);
            bus.o_ERR  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (r_state == S_IDLE);
  assign bus.o_valid = (r_state == S_DONE);
endmodule
